// File: rtl/lamp_state.sv
// Lamp bank driver: turns a lamp count into a registered thermometer code,
// lowest-index lamps lit first, one clock of latency.
module lamp_state (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  active_lights,
   output logic [15:0] lights_state
);

   logic [15:0] decoded;

   // Lamp i is lit when the requested count exceeds i. The loop stops at 14,
   // so bit 15 is never set: a 4-bit count tops out at 15 lamps.
   always_comb begin
      decoded = '0;
      for (int i = 0; i < 15; i++) begin
         decoded[i] = (active_lights > 4'(i));
      end
   end

   // NOTE: state is updated with <= so every flop samples pre-edge values.
   // The reset branch is asynchronous and clears all lamps at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lights_state <= '0;
      end else begin
         lights_state <= decoded;
      end
   end

endmodule

// File: tb/tb_lamp_state.sv
// Self-checking bench for lamp_state: directed steps plus randomized counts
// checked against an arithmetic (2^N - 1) model of the thermometer code.
module tb_lamp_state;

   logic        clk;
   logic        rst_n;
   logic [3:0]  active_lights;
   logic [15:0] lights_state;

   int vectors;
   int miscompares;

   lamp_state dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .active_lights (active_lights),
      .lights_state  (lights_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence never completes.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Reference: N lamps lit from the bottom is 2^N - 1.
   function automatic logic [15:0] model(input int n);
      int v;
      v = (1 << n) - 1;
      return v[15:0];
   endfunction

   task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Change input away from the edge, clock once, sample just after the edge.
   task automatic step(input int n);
      @(negedge clk);
      active_lights = 4'(n);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      rst_n         = 1'b0;
      active_lights = 4'b1111;

      // Held in reset with the maximum count: lamps must stay dark.
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         check("reset_hold", lights_state, 16'h0000);
      end

      // First edge after release loads the current count.
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release_before_edge", lights_state, 16'h0000);
      @(posedge clk);
      #1;
      check("release_first_edge", lights_state, model(15));

      // Directed decode sweep.
      begin
         int sweep [7] = '{0, 10, 0, 15, 3, 6, 8};
         logic [15:0] want [7] = '{16'h0000, 16'h03FF, 16'h0000, 16'h7FFF,
                                   16'h0007, 16'h003F, 16'h00FF};
         for (int k = 0; k < 7; k++) begin
            step(sweep[k]);
            check($sformatf("sweep_%0d", sweep[k]), lights_state, want[k]);
         end
      end

      // Every count, with the top lamp always dark.
      for (int n = 0; n < 16; n++) begin
         step(n);
         check($sformatf("exhaustive_%0d", n), lights_state, model(n));
         check($sformatf("bit15_%0d", n), {15'd0, lights_state[15]}, 16'h0000);
      end

      // Latency: new count is invisible until the next edge.
      step(0);
      check("latency_zero", lights_state, 16'h0000);
      @(negedge clk);
      active_lights = 4'd5;
      #1;
      check("latency_same_edge", lights_state, 16'h0000);
      @(posedge clk);
      #1;
      check("latency_next_edge", lights_state, 16'h001F);

      // Mid-run reset between edges clears immediately.
      step(15);
      check("midrun_full", lights_state, 16'h7FFF);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrun_async_clear", lights_state, 16'h0000);
      active_lights = 4'd9;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midrun_released", lights_state, 16'h0000);
      @(posedge clk);
      #1;
      check("midrun_reload", lights_state, model(9));

      // Hold: constant count keeps output stable.
      for (int k = 0; k < 10; k++) begin
         step(6);
         check($sformatf("hold_%0d", k), lights_state, 16'h003F);
      end

      // Randomized counts, with occasional asynchronous reset pulses.
      for (int k = 0; k < 300; k++) begin
         int n;
         n = int'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) begin
            @(negedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check("random_reset", lights_state, 16'h0000);
            #1;
            rst_n = 1'b1;
         end
         step(n);
         check($sformatf("random_%0d", n), lights_state, model(n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lamp_state.md
LAMP_STATE -- requirements
Module: lamp_state

Interface
REQ-001 The block SHALL have no parameters; widths are fixed as listed below.
REQ-002 The port clk SHALL be an input, 1 bit wide, and SHALL be the single system clock; all state updates on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide, and SHALL be the asynchronous, active-low reset.
REQ-004 The port active_lights SHALL be an input, 4 bits wide, carrying the number of lamps to turn on, unsigned 0..15.
REQ-005 The port lights_state SHALL be an output, 16 bits wide, with one bit per lamp; bit i = 1 means lamp i is on.
REQ-006 The block SHALL have no other ports.

Function
REQ-007 The block SHALL decode active_lights into a thermometer code: for count N, bits [N-1:0] = 1 and bits [15:N] = 0.
REQ-008 The decoded value SHALL equal (2^N) - 1 as a 16-bit value, with the lowest-index lamps lit first.
REQ-009 lights_state SHALL be driven directly from an output register, with no combinational path from active_lights to lights_state.
REQ-010 Latency SHALL be exactly 1 clock: the value of active_lights sampled at rising edge k appears on lights_state immediately after edge k.
REQ-011 active_lights SHALL be sampled on every rising edge, with no enable and no handshake; the output tracks the input continuously with 1-cycle delay.
REQ-012 lights_state[15] SHALL be 0 under all conditions, because the maximum count 15 lights bits [14:0] only.
REQ-013 N = 0 SHALL produce 16'h0000, and N = 15 SHALL produce 16'h7FFF.
REQ-014 Any change of N SHALL take effect fully in one cycle, in both directions (increase or decrease), with no ramping and no intermediate codes.
REQ-015 Repeated identical inputs SHALL leave lights_state unchanged, with no glitch on the register output.
REQ-016 Any legal thermometer code SHALL be reachable from any other in a single cycle.

Reset
REQ-017 While rst_n = 0, lights_state SHALL be 16'h0000 asynchronously, independent of clk.
REQ-018 Deassertion of rst_n SHALL be synchronised by the first rising clk edge.
REQ-019 The first edge with rst_n = 1 SHALL load the decode of the current active_lights.
REQ-020 Reset asserted mid-operation SHALL clear all lamps immediately, with no wait for a clock edge.
REQ-021 After release, normal 1-cycle-latency operation SHALL resume with no recovery cycles.

Verification
REQ-022 Reset check: hold rst_n = 0 with active_lights = 4'b1111 and toggle clk; lights_state SHALL remain 16'h0000.
REQ-023 Decode sweep, using one clock per step: apply active_lights 0000, 1010, 0000, 1111, 0011, 0110, 1000; one cycle later lights_state SHALL be, respectively, 16'h0000, 16'h03FF, 16'h0000, 16'h7FFF, 16'h0007, 16'h003F, 16'h00FF.
REQ-024 Exhaustive check: for each N in 0..15, lights_state SHALL equal (1 << N) - 1 one cycle later, and bit 15 SHALL always be 0.
REQ-025 Latency check: step active_lights from 0 to 5; at the same edge lights_state SHALL still be 16'h0000, and after the next edge it SHALL be 16'h001F.
REQ-026 Mid-run reset: with lights_state = 16'h7FFF, pulse rst_n low between clock edges; lights_state SHALL go to 16'h0000 immediately. After release, the first edge SHALL reload the decode of active_lights.
REQ-027 Hold check: keep active_lights constant at 4'b0110 for 10 cycles; lights_state SHALL stay stable at 16'h003F throughout.
